u_divider_8bit: RTL and testbench

- Sequential unsigned restoring divider, 8-bit default. It is the inverse operation to the team's shift-add unsigned multiplier.
- Computes quotient and remainder of dividend a by divisor b, one quotient bit per clock.
- Signals completion on eop. Sits beside the multiplier in the arithmetic unit and shares its clock and reset.

---
 rtl/u_divider_8bit.sv | 154 +++++++++++++++
 tb/tb_u_divider_8bit.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/u_divider_8bit.sv
// u_divider_8bit: sequential unsigned restoring divider.
// Produces one quotient bit per clock. Dividend a and divisor b are sampled on
// the accepting edge. quot and rem are valid while eop is high.
// All state updates happen on the falling edge of clock, the same edge the
// companion shift-add multiplier uses.
// Optional build macro U_DIVIDER_DIV_ZERO_FLAG_EN adds a dbz output and a
// one-cycle fast path for a zero divisor.
module u_divider_8bit #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             busy,
`ifdef U_DIVIDER_DIV_ZERO_FLAG_EN
  output logic             dbz,
`endif
  output logic             eop
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] divisor;
  logic             accept;

  // One restoring step. The partial remainder is widened by one bit so that
  // the shifted-out MSB of rem takes part in the compare.
  logic [WIDTH:0]   t;
  logic             ge;
  logic [WIDTH-1:0] rem_sub;
  logic [WIDTH-1:0] rem_step;

  assign accept = start && ((state == IDLE) || (state == DONE));

  assign t  = {rem, quot[WIDTH-1]};
  assign ge = (t >= {1'b0, divisor});
  // When ge holds, the true difference is below divisor and fits in WIDTH
  // bits. Modular subtraction of the low bits therefore gives the exact result.
  assign rem_sub  = t[WIDTH-1:0] - divisor;
  assign rem_step = ge ? rem_sub : t[WIDTH-1:0];

  // State register; reset overrides everything, including a running division
  always_ff @(negedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = CALC;
        end
      end
      CALC: begin
`ifdef U_DIVIDER_DIV_ZERO_FLAG_EN
        if (dbz || (count == CW'(1))) begin
          state_next = DONE;
        end
`else
        if (count == CW'(1)) begin
          state_next = DONE;
        end
`endif
      end
      DONE: begin
        state_next = start ? CALC : IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output decode: busy during iteration, eop for the single DONE cycle
  always_comb begin
    busy = 1'b0;
    eop  = 1'b0;
    case (state)
      CALC:    busy = 1'b1;
      DONE:    eop  = 1'b1;
      default: begin
        busy = 1'b0;
        eop  = 1'b0;
      end
    endcase
  end

  // Working registers: quot doubles as the dividend shift register
  always_ff @(negedge clock) begin
    if (reset) begin
      quot  <= '0;
      rem   <= '0;
      count <= '0;
    end else if (accept) begin
      quot  <= a;
      rem   <= '0;
      count <= CW'(WIDTH);
    end else if (state == CALC) begin
`ifdef U_DIVIDER_DIV_ZERO_FLAG_EN
      if (dbz) begin
        // Result that the full iteration would produce for a zero divisor
        quot <= '1;
        rem  <= quot;
      end else begin
        quot <= {quot[WIDTH-2:0], ge};
        rem  <= rem_step;
      end
`else
      quot  <= {quot[WIDTH-1-1:0], ge};
      rem   <= rem_step;
`endif
      count <= count - CW'(1);
    end
  end

  // The divisor is only ever read in CALC, after it has been loaded, so it
  // needs no reset
  always_ff @(negedge clock) begin
    if (accept) begin
      divisor <= b;
    end
  end

`ifdef U_DIVIDER_DIV_ZERO_FLAG_EN
  // Divide-by-zero flag, captured with the operands
  always_ff @(negedge clock) begin
    if (reset) begin
      dbz <= 1'b0;
    end else if (accept) begin
      dbz <= (b == '0);
    end
  end
`endif

endmodule

// File: tb/tb_u_divider_8bit.sv
// tb_u_divider_8bit: directed-vector bench for u_divider_8bit (WIDTH=8).
// The DUT updates on the falling edge. The bench drives inputs and samples
// outputs 1 time unit after the rising edge.
module tb_u_divider_8bit;

  localparam int W = 8;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic [W-1:0] quot;
  logic [W-1:0] rem;
  logic         busy;
  logic         eop;
`ifdef U_DIVIDER_DIV_ZERO_FLAG_EN
  logic         dbz;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  u_divider_8bit #(.WIDTH(W)) dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .quot  (quot),
    .rem   (rem),
    .busy  (busy),
`ifdef U_DIVIDER_DIV_ZERO_FLAG_EN
    .dbz   (dbz),
`endif
    .eop   (eop)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Present operands with start high across exactly one falling edge
  task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv);
    @(posedge clock); #1;
    a     = av;
    b     = bv;
    start = 1'b1;
    @(negedge clock); #1;
    start = 1'b0;
  endtask

  // Count busy cycles until eop is seen; returns with time at that sample point
  task automatic run_to_eop(output int nbusy, output bit ok);
    nbusy = 0;
    ok    = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock); #1;
      if (eop) begin
        ok = 1'b1;
        break;
      end
      if (busy) nbusy++;
    end
  endtask

  task automatic one_div(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input int eq, input int er, input int ebusy);
    int  nb;
    bit  ok;
    start_op(av, bv);
    run_to_eop(nb, ok);
    chk({tag, "_eop_seen"}, ok, 1);
    chk({tag, "_busy_cycles"}, nb, ebusy);
    chk({tag, "_quot"}, quot, eq);
    chk({tag, "_rem"}, rem, er);
`ifdef U_DIVIDER_DIV_ZERO_FLAG_EN
    chk({tag, "_dbz"}, dbz, (bv == 0) ? 1 : 0);
`endif
    @(posedge clock); #1;
    chk({tag, "_eop_single"}, eop, 0);
    chk({tag, "_hold_quot"}, quot, eq);
  endtask

  initial begin
    int nb;
    int seen;
    bit ok;

    // Reset state
    repeat (2) @(negedge clock);
    @(posedge clock); #1;
    chk("rst_quot", quot, 0);
    chk("rst_rem", rem, 0);
    chk("rst_busy", busy, 0);
    chk("rst_eop", eop, 0);
    reset = 1'b0;

    one_div("d255_15", 8'd255, 8'd15, 17, 0, 8);
    one_div("d200_7", 8'd200, 8'd7, 28, 4, 8);
    one_div("d5_10", 8'd5, 8'd10, 0, 5, 8);
    one_div("d0_1", 8'd0, 8'd1, 0, 0, 8);
    one_div("d255_255", 8'd255, 8'd255, 1, 0, 8);
    one_div("d254_255", 8'd254, 8'd255, 0, 254, 8);
`ifdef U_DIVIDER_DIV_ZERO_FLAG_EN
    one_div("d100_0", 8'd100, 8'd0, 255, 100, 1);
`else
    one_div("d100_0", 8'd100, 8'd0, 255, 100, 8);
`endif

    // start during CALC cycle 3 is ignored
    start_op(8'd255, 8'd1);
    repeat (3) @(posedge clock);
    #1;
    chk("ign_busy_c3", busy, 1);
    a     = 8'd9;
    b     = 8'd3;
    start = 1'b1;
    @(negedge clock); #1;
    start = 1'b0;
    run_to_eop(nb, ok);
    chk("ign_eop_seen", ok, 1);
    chk("ign_busy_total", nb + 3, 8);
    chk("ign_quot", quot, 255);
    chk("ign_rem", rem, 0);

    // Back-to-back: restart in the eop cycle
    start_op(8'd170, 8'd85);
    run_to_eop(nb, ok);
    chk("b2b1_eop_seen", ok, 1);
    chk("b2b1_quot", quot, 2);
    chk("b2b1_rem", rem, 0);
    a     = 8'd240;
    b     = 8'd15;
    start = 1'b1;
    @(negedge clock); #1;
    start = 1'b0;
    run_to_eop(nb, ok);
    chk("b2b2_eop_seen", ok, 1);
    chk("b2b2_busy_cycles", nb, 8);
    chk("b2b2_quot", quot, 16);
    chk("b2b2_rem", rem, 0);

    // Reset in CALC cycle 4 aborts the division
    start_op(8'd200, 8'd7);
    repeat (4) @(posedge clock);
    #1;
    chk("abort_busy_c4", busy, 1);
    reset = 1'b1;
    @(negedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    chk("abort_busy", busy, 0);
    chk("abort_eop", eop, 0);
    chk("abort_quot", quot, 0);
    chk("abort_rem", rem, 0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clock); #1;
      if (eop || busy) seen++;
    end
    chk("abort_no_activity", seen, 0);

    // Operation after the abort is normal
    one_div("post_abort", 8'd13, 8'd4, 3, 1, 8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
